// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: per-input request streams plus shared output stream of the round-robin arbiter
interface stream_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH = $clog2(NUM_INPUTS);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data;
  logic [NUM_INPUTS-1:0]            i_last;
  logic [NUM_INPUTS-1:0]            i_input_valid;
  logic [NUM_INPUTS-1:0]            o_input_ready;
  logic [DATA_WIDTH-1:0]            o_data;
  logic                             o_last;
  logic [ID_WIDTH-1:0]              o_grant_id;
  logic                             o_output_valid;
  logic                             i_output_ready;
  modport master (
    output i_data, i_last, i_input_valid, i_output_ready,
    input  o_input_ready, o_data, o_last, o_grant_id, o_output_valid
  );
  modport slave (
    input  i_data, i_last, i_input_valid, i_output_ready,
    output o_input_ready, o_data, o_last, o_grant_id, o_output_valid
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N:1 stream arbiter with a registered two-entry skid output; define LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN to hold the grant for a whole packet
module stream_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                i_clock,
  input logic                i_aresetn,
  input logic                i_clear,
  stream_rr_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_INPUTS);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
  } beat_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t              state, next_state;
  beat_t               out_beat, skid_beat, in_beat;
  logic [ID_WIDTH-1:0] ptr, grant, idx, next_ptr;
  logic                found, can_accept, out_valid, accept, transmit, advance;
`ifdef LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN
  logic                locked;
  logic [ID_WIDTH-1:0] lock_id;
`endif
  // first valid input at or above the pointer wins; scanning downward lets the nearest one overwrite
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      idx = ID_WIDTH'((int'(ptr) + i) % NUM_INPUTS);
      if (bus.i_input_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
`ifdef LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN
    if (locked) begin
      grant = lock_id;
      found = 1'b1;
    end
`endif
  end
  assign bus.o_input_ready = (found && can_accept) ? (NUM_INPUTS'(1) << grant) : '0;
  assign accept   = |(bus.i_input_valid & bus.o_input_ready);
  assign transmit = out_valid & bus.i_output_ready;
  assign in_beat  = {bus.i_data[grant*DATA_WIDTH +: DATA_WIDTH], bus.i_last[grant], grant};
  assign next_ptr = (grant == ID_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
`ifdef LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN
  assign advance  = accept & in_beat.last;
`else
  assign advance  = accept;
`endif
  // occupancy tracking: EMPTY/BUSY/FULL = 0/1/2 beats buffered
  always_comb begin
    next_state = EMPTY;
    case (state)
      EMPTY:   next_state = accept ? BUSY : EMPTY;
      BUSY:    next_state = (accept && !transmit) ? FULL : (!accept && transmit) ? EMPTY : BUSY;
      FULL:    next_state = transmit ? BUSY : FULL;
      default: next_state = EMPTY;
    endcase
  end
  // state plus registered flags derived from the next occupancy
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state      <= EMPTY;
      can_accept <= 1'b0;
      out_valid  <= 1'b0;
    end else if (i_clear) begin
      state      <= EMPTY;
      can_accept <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= next_state;
      can_accept <= next_state != FULL;
      out_valid  <= next_state != EMPTY;
    end
  end
  // output and skid registers; the skid drains into the output when the front beat leaves
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      out_beat  <= '0;
      skid_beat <= '0;
    end else if (i_clear) begin
      out_beat  <= '0;
      skid_beat <= '0;
    end else begin
      if ((state == EMPTY && accept) || (state == BUSY && accept && transmit)) out_beat <= in_beat;
      else if (state == FULL && transmit) out_beat <= skid_beat;
      if (state == BUSY && accept && !transmit) skid_beat <= in_beat;
    end
  end
`ifdef LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN
  // round-robin pointer moves past a winner only at packet end; lock pins the grant mid-packet
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (i_clear) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else begin
      if (advance) ptr <= next_ptr;
      if (accept) begin
        locked  <= !in_beat.last;
        lock_id <= grant;
      end
    end
  end
`else
  // round-robin pointer moves past the winner on every accepted beat
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) ptr <= '0;
    else if (i_clear) ptr <= '0;
    else if (advance) ptr <= next_ptr;
  end
`endif
  assign bus.o_data         = out_beat.data;
  assign bus.o_last         = out_beat.last;
  assign bus.o_grant_id     = out_beat.id;
  assign bus.o_output_valid = out_valid;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for stream_rr_arbiter (4 inputs, 32-bit data)
module tb_stream_rr_arbiter;
  typedef struct packed {
    logic [1:0]  id;
    logic        last;
    logic [31:0] data;
  } tb_beat_t;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  mute = '0;
  logic [3:0]  obs_ready;
  logic        obs_valid;
  logic [31:0] obs_data;
  logic [1:0]  obs_id;
  int          checks = 0;
  int          errors = 0;
  int          tx_count = 0;
  tb_beat_t    src_q [4][$];
  tb_beat_t    exp_q [$];
  stream_rr_arbiter_if #(.NUM_INPUTS(4), .DATA_WIDTH(32)) bus ();
  stream_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32)) dut (
    .i_clock   (clk),
    .i_aresetn (aresetn),
    .i_clear   (clear),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic apply();
    logic [127:0] d;
    logic [3:0]   v, l;
    d = '0; v = '0; l = '0;
    for (int k = 0; k < 4; k++)
      if (src_q[k].size() > 0 && !mute[k]) begin
        v[k] = 1'b1;
        l[k] = src_q[k][0].last;
        d[k*32 +: 32] = src_q[k][0].data;
      end
    bus.i_input_valid = v;
    bus.i_last = l;
    bus.i_data = d;
  endtask
  task automatic send(input int k, input logic [31:0] d, input logic l, input bit expect_it);
    tb_beat_t b;
    b.id = 2'(k); b.last = l; b.data = d;
    src_q[k].push_back(b);
    if (expect_it) exp_q.push_back(b);
  endtask
  task automatic expect_beat(input int k, input logic [31:0] d, input logic l);
    tb_beat_t b;
    b.id = 2'(k); b.last = l; b.data = d;
    exp_q.push_back(b);
  endtask
  task automatic cycle();
    logic [3:0] hs;
    tb_beat_t   e;
    @(negedge clk);
    obs_ready = bus.o_input_ready;
    obs_valid = bus.o_output_valid;
    obs_data  = bus.o_data;
    obs_id    = bus.o_grant_id;
    hs = bus.i_input_valid & bus.o_input_ready;
    if (bus.o_output_valid && bus.i_output_ready) begin
      tx_count++;
      if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check("out_id", 32'(bus.o_grant_id), 32'(e.id));
        check("out_last", 32'(bus.o_last), 32'(e.last));
        check("out_data", bus.o_data, e.data);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) if (hs[k]) void'(src_q[k].pop_front());
    apply();
  endtask
  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) cycle();
    check("drain_empty", 32'(exp_q.size()), 0);
    repeat (3) cycle();
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    clear = 1'b0;
    mute = '0;
    bus.i_output_ready = 1'b1;
    for (int k = 0; k < 4; k++) src_q[k].delete();
    exp_q.delete();
    apply();
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    tx_count = 0;
  endtask
  initial begin
    // two requesters alternate; reset values seen in cycle 0
    do_reset();
    send(0, 32'h100, 1'b0, 0); send(0, 32'h101, 1'b0, 0); send(0, 32'h102, 1'b1, 0);
    send(2, 32'h200, 1'b0, 0); send(2, 32'h201, 1'b1, 0);
    expect_beat(0, 32'h100, 1'b0); expect_beat(2, 32'h200, 1'b0); expect_beat(0, 32'h101, 1'b0);
    expect_beat(2, 32'h201, 1'b1); expect_beat(0, 32'h102, 1'b1);
    apply();
    cycle();
    check("rst_ready", 32'(obs_ready), 0);
    check("rst_valid", 32'(obs_valid), 0);
    check("rst_data", obs_data, 0);
    check("rst_id", 32'(obs_id), 0);
    cycle(); check("rr_ready_c1", 32'(obs_ready), 32'b0001);
    cycle(); check("rr_ready_c2", 32'(obs_ready), 32'b0100);
    cycle(); check("rr_ready_c3", 32'(obs_ready), 32'b0001);
    drain();
    // all four busy: strict rotation without bubbles
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) send(k, 32'h300 + 32'(r*4 + k), 1'b1, 1);
    apply();
    repeat (10) cycle();
    check("no_bubbles", 32'(tx_count), 8);
    drain();
    // back-pressure fills both registers and holds the front beat
    do_reset();
    bus.i_output_ready = 1'b0;
    send(1, 32'hA1, 1'b0, 1); send(1, 32'hA2, 1'b0, 1); send(1, 32'hA3, 1'b1, 1);
    apply();
    repeat (4) cycle();
    check("full_ready", 32'(obs_ready), 0);
    check("full_valid", 32'(obs_valid), 1);
    check("full_data", obs_data, 32'hA1);
    cycle();
    check("hold_data", obs_data, 32'hA1);
    check("hold_id", 32'(obs_id), 1);
    bus.i_output_ready = 1'b1;
    drain();
    // a request withdrawn before any handshake is never forwarded
    do_reset();
    send(3, 32'h55, 1'b1, 0);
    send(1, 32'h11, 1'b1, 1);
    mute = 4'b0010;
    apply();
    cycle();
    check("drop_ready_c0", 32'(obs_ready), 0);
    mute = 4'b1000;
    apply();
    cycle();
    check("drop_ready_c1", 32'(obs_ready), 32'b0010);
    drain();
    src_q[3].delete();
    mute = '0;
    apply();
    // synchronous clear while full discards buffered beats and resets the pointer
    bus.i_output_ready = 1'b0;
    send(2, 32'h400, 1'b0, 0); send(2, 32'h401, 1'b0, 0); send(2, 32'h402, 1'b1, 0);
    apply();
    repeat (4) cycle();
    check("pre_clear_ready", 32'(obs_ready), 0);
    check("pre_clear_valid", 32'(obs_valid), 1);
    clear = 1'b1;
    src_q[2].delete();
    apply();
    cycle();
    clear = 1'b0;
    cycle();
    check("clear_valid", 32'(obs_valid), 0);
    check("clear_data", obs_data, 0);
    check("clear_ready", 32'(obs_ready), 0);
    for (int k = 0; k < 4; k++) send(k, 32'h500 + 32'(k), 1'b1, 1);
    bus.i_output_ready = 1'b1;
    apply();
    drain();
    // three-beat packet from input 0 competing with input 1
    do_reset();
    send(0, 32'h600, 1'b0, 0); send(0, 32'h601, 1'b0, 0); send(0, 32'h602, 1'b1, 0);
    send(1, 32'h610, 1'b1, 0); send(1, 32'h611, 1'b1, 0);
`ifdef LIBSV_STREAM_RR_ARBITER_PACKET_LOCK_EN
    expect_beat(0, 32'h600, 1'b0); expect_beat(0, 32'h601, 1'b0); expect_beat(0, 32'h602, 1'b1);
    expect_beat(1, 32'h610, 1'b1); expect_beat(1, 32'h611, 1'b1);
`else
    expect_beat(0, 32'h600, 1'b0); expect_beat(1, 32'h610, 1'b1); expect_beat(0, 32'h601, 1'b0);
    expect_beat(1, 32'h611, 1'b1); expect_beat(0, 32'h602, 1'b1);
`endif
    apply();
    drain();
    // asynchronous reset mid-transfer clears outputs without a clock edge
    bus.i_output_ready = 1'b0;
    send(0, 32'h700, 1'b0, 0); send(0, 32'h701, 1'b1, 0);
    apply();
    repeat (3) cycle();
    check("pre_arst_valid", 32'(obs_valid), 1);
    aresetn = 1'b0;
    #1;
    check("arst_valid", 32'(bus.o_output_valid), 0);
    check("arst_data", bus.o_data, 0);
    check("arst_ready", 32'(bus.o_input_ready), 0);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
